// File: rtl/riscv_mmio_bridge.sv
// riscv_mmio_bridge: decodes the 0xFFFFFC00 I/O window and provides switches, GPO, keyboard and timer registers
module riscv_mmio_bridge #(
  parameter int NUM_GPO     = 2,
  parameter int SW_WIDTH    = 24,
  parameter int KB_WIDTH    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic                  wr_en,
  input  logic [1:0]            wr_size,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_wr_en,
  output logic [31:0]           rdata,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic                  kb_valid,
  input  logic [KB_WIDTH-1:0]   kb_code,
  output logic [NUM_GPO*32-1:0] gpo,
  output logic                  timer_irq
);
  logic                is_io, io_wr, wr_st, wr_tm, wr_cmp, rd_kb, kb_take;
  logic [5:0]          idx;
  logic [31:0]         mask, wdat, wm, io_rd, timer, cmp, status_merge;
  logic [SW_WIDTH-1:0] sync [SYNC_STAGES];
  logic [31:0]         gpo_r [NUM_GPO];
  logic [KB_WIDTH-1:0] kb_code_r;
  logic                kb_v, kb_ovf, tmatch;
  assign is_io     = (addr & 32'hFFFF_FF00) == 32'hFFFF_FC00;
  assign idx       = addr[7:2];
  assign mem_wr_en = wr_en & ~is_io;
  assign io_wr     = wr_en & is_io;
  assign wr_st     = io_wr && idx == 6'h11;
  assign wr_tm     = io_wr && idx == 6'h12;
  assign wr_cmp    = io_wr && idx == 6'h13;
  assign rd_kb     = rd_en && is_io && idx == 6'h10;
  assign kb_take   = kb_valid & (~kb_v | rd_kb);
  assign timer_irq = tmatch;
  assign rdata     = is_io ? io_rd : mem_rdata;
  // Sub-word stores replicate data across lanes; the mask selects the lane to merge.
  always_comb begin
    mask = wr_size == 2'b00 ? 32'h0000_00FF << {addr[1:0], 3'b000} :
           wr_size == 2'b01 ? (addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
    wdat = wr_size == 2'b00 ? {4{wr_data[7:0]}} :
           wr_size == 2'b01 ? {2{wr_data[15:0]}} : wr_data;
    wm   = wdat & mask;
    status_merge = wr_st ? wm : 32'h0;
  end
  always_comb begin
    io_rd = 32'h0;
    if (idx == 6'h00) io_rd = 32'(sync[SYNC_STAGES-1]);
    for (int i = 0; i < NUM_GPO; i++)
      if (idx == 6'(i + 1)) io_rd = gpo_r[i];
    if (idx == 6'h10) io_rd = 32'(kb_code_r) | {kb_v, 31'h0};
    if (idx == 6'h11) io_rd = {29'h0, tmatch, kb_ovf, kb_v};
    if (idx == 6'h12) io_rd = timer;
    if (idx == 6'h13) io_rd = cmp;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  for (genvar g = 0; g < NUM_GPO; g++) begin : g_gpo
    assign gpo[32*g +: 32] = gpo_r[g];
    always_ff @(posedge clk or posedge rst)
      if (rst) gpo_r[g] <= 32'h0;
      else if (io_wr && idx == 6'(g + 1)) gpo_r[g] <= (gpo_r[g] & ~mask) | wm;
  end
  // A load of KB_DATA in the same cycle as a new code frees the slot, so no overflow.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      kb_code_r <= '0;
      kb_v      <= 1'b0;
      kb_ovf    <= 1'b0;
    end else begin
      if (kb_take) kb_code_r <= kb_code;
      kb_v   <= kb_valid | (kb_v & ~rd_kb);
      kb_ovf <= (kb_ovf & ~status_merge[1]) | (kb_valid & kb_v & ~rd_kb);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer  <= 32'h0;
      cmp    <= 32'hFFFF_FFFF;
      tmatch <= 1'b0;
    end else begin
      timer  <= wr_tm ? (timer & ~mask) | wm : timer + 32'h1;
      if (wr_cmp) cmp <= (cmp & ~mask) | wm;
      tmatch <= (tmatch & ~status_merge[2]) | (timer == cmp);
    end
endmodule

// File: tb/tb_riscv_mmio_bridge.sv
// tb_riscv_mmio_bridge: directed self-checking bench for the MMIO bridge
module tb_riscv_mmio_bridge;
  logic        clk = 0, rst = 1;
  logic [31:0] addr = 0, wr_data = 0, mem_rdata = 0, rdata;
  logic [1:0]  wr_size = 0;
  logic        wr_en = 0, rd_en = 0, mem_wr_en, kb_valid = 0, timer_irq;
  logic [23:0] sw = 0;
  logic [4:0]  kb_code = 0;
  logic [63:0] gpo;
  int checks = 0, errors = 0;
  localparam logic [31:0] B = 32'hFFFF_FC00;
  riscv_mmio_bridge dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wr_size(wr_size), .wr_data(wr_data),
    .rd_en(rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .rdata(rdata), .sw(sw),
    .kb_valid(kb_valid), .kb_code(kb_code), .gpo(gpo), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input logic me);
    addr = a; wr_data = d; wr_size = s; wr_en = 1;
    #1 chk("mem_wr_en", {31'h0, mem_wr_en}, {31'h0, me});
    tick();
    wr_en = 0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 chk(tag, rdata, exp);
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    rd("reset_timer", B + 32'h48, 32'h0);
    rd("reset_gpo0", B + 32'h04, 32'h0);
    rd("reset_cmp", B + 32'h4C, 32'hFFFF_FFFF);
    chk("reset_irq", {31'h0, timer_irq}, 32'h0);
    rd("reset_status", B + 32'h44, 32'h0);
    wr(B + 32'h04, 32'h1234_5678, 2'b10, 1'b0);
    rd("gpo0_word", B + 32'h04, 32'h1234_5678);
    wr(B + 32'h06, 32'hFFFF_FFAB, 2'b00, 1'b0);
    rd("gpo0_byte", B + 32'h04, 32'h12AB_5678);
    wr(B + 32'h04, 32'h0000_CDEF, 2'b01, 1'b0);
    rd("gpo0_half", B + 32'h04, 32'h12AB_CDEF);
    chk("gpo0_port", gpo[31:0], 32'h12AB_CDEF);
    wr(B + 32'h0A, 32'h0000_BEEF, 2'b01, 1'b0);
    chk("gpo1_hihalf", gpo[63:32], 32'hBEEF_0000);
    wr(32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 1'b1);
    chk("mem_write_no_gpo", gpo[31:0], 32'h12AB_CDEF);
    mem_rdata = 32'h55AA_33CC;
    rd("mem_read", 32'h0000_1000, 32'h55AA_33CC);
    rd("unmapped", B + 32'h80, 32'h0);
    rd("outside_window", 32'hFFFF_FD04, 32'h55AA_33CC);
    sw = 24'hA5A5A5;
    rd("sw_c1", B, 32'h0);
    tick();
    rd("sw_c2", B, 32'h0);
    tick();
    rd("sw_c3", B, 32'h00A5_A5A5);
    kb_valid = 1; kb_code = 5; tick();
    kb_code = 9; tick();
    kb_valid = 0;
    rd("kb_first", B + 32'h40, 32'h8000_0005);
    rd("status_ovf", B + 32'h44, 32'h3);
    addr = B + 32'h40; rd_en = 1; kb_valid = 1; kb_code = 7; tick();
    rd_en = 0; kb_valid = 0;
    rd("kb_readswap", B + 32'h40, 32'h8000_0007);
    rd("status_keep", B + 32'h44, 32'h3);
    wr(B + 32'h44, 32'h2, 2'b10, 1'b0);
    rd("status_w1c", B + 32'h44, 32'h1);
    addr = B + 32'h40; rd_en = 1; tick();
    rd_en = 0;
    rd("kb_cleared", B + 32'h40, 32'h0000_0007);
    repeat (20) tick();
    wr(B + 32'h4C, 32'd10, 2'b10, 1'b0);
    wr(B + 32'h48, 32'h0, 2'b10, 1'b0);
    rd("timer_zero", B + 32'h48, 32'h0);
    for (int k = 1; k <= 10; k++) tick();
    rd("timer_ten", B + 32'h48, 32'd10);
    chk("irq_before", {31'h0, timer_irq}, 32'h0);
    tick();
    chk("irq_rise", {31'h0, timer_irq}, 32'h1);
    rd("status_match", B + 32'h44, 32'h4);
    repeat (3) tick();
    chk("irq_sticky", {31'h0, timer_irq}, 32'h1);
    wr(B + 32'h44, 32'h4, 2'b10, 1'b0);
    chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
    wr(B + 32'h4D, 32'h12, 2'b00, 1'b0);
    rd("cmp_byte", B + 32'h4C, 32'h0000_120A);
    wr(B + 32'h48, 32'hFFFF_FFFF, 2'b10, 1'b0);
    rd("timer_max", B + 32'h48, 32'hFFFF_FFFF);
    tick();
    rd("timer_wrap", B + 32'h48, 32'h0);
    rst = 1;
    #1 chk("async_rst_gpo", gpo[31:0], 32'h0);
    rd("async_rst_sw", B, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
